// File: rtl/laplace_lut_pkg.sv
// Shared constants and state encoding for the Laplace LUT sequencer.
// The state codes also appear on the which_state debug output.
package laplace_lut_pkg;

    localparam int unsigned ROM_ADDR_W = 10;
    localparam int unsigned BASE_SHIFT = 2;
    localparam int unsigned DIR_STRIDE = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_BASE = 4'd1,
        ST_RD_LEN  = 4'd2,
        ST_LEN_CAP = 4'd3,
        ST_FETCH   = 4'd4,
        ST_CAPT    = 4'd5,
        ST_PRESENT = 4'd6,
        ST_DONE    = 4'd7
    } state_e;

endpackage

// File: rtl/laplace_lut_sequencer.sv
// Reads a directory record from the character ROM, then streams that entry's
// characters one at a time over a valid/ready byte interface.
import laplace_lut_pkg::*;

module laplace_lut_sequencer #(
    parameter int IDX_W = 5,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  abort,
    output logic                  rom_rd,
    output logic [9:0]            rom_addr,
    input  logic [7:0]            rom_data,
    output logic [7:0]            out_char,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      chars_remaining,
    output logic [3:0]            which_state
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e                  state_r;
    state_e                  state_next_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_next_s;
    logic [7:0]              base_r;
    logic [ROM_ADDR_W-1:0]   k_r;
    logic [ROM_ADDR_W-1:0]   k_next_s;
    logic [LEN_W-1:0]        remaining_r;
    logic [LEN_W-1:0]        remaining_next_s;
    logic [ROM_ADDR_W-1:0]   dir_addr_s;
    logic [ROM_ADDR_W-1:0]   addr_next_s;
    logic                    handshake_s;
    logic                    rom_rd_r;
    logic [ROM_ADDR_W-1:0]   rom_addr_r;
    logic [7:0]              out_char_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    done_r;

    // Next-state, captured index, offset and remaining-count logic.
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        k_next_s         = k_r;
        remaining_next_s = remaining_r;
        handshake_s      = (state_r == ST_PRESENT) && out_valid_r && out_ready;
        if (abort && (state_r != ST_IDLE)) begin
            state_next_s     = ST_IDLE;
            remaining_next_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_RD_BASE;
                        idx_next_s   = idx;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RD_BASE: state_next_s = ST_RD_LEN;
                ST_RD_LEN:  state_next_s = ST_LEN_CAP;
                ST_LEN_CAP: begin
                    remaining_next_s = LEN_W'(rom_data);
                    k_next_s         = '0;
                    if (rom_data == 8'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_FETCH:   state_next_s = ST_CAPT;
                ST_CAPT:    state_next_s = ST_PRESENT;
                ST_PRESENT: begin
                    if (handshake_s) begin
                        remaining_next_s = remaining_r - LEN_ONE;
                        k_next_s         = k_r + 10'd1;
                        if (remaining_r == LEN_ONE) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_FETCH;
                        end
                    end else begin
                        state_next_s = ST_PRESENT;
                    end
                end
                ST_DONE:    state_next_s = ST_IDLE;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // ROM address for the state being entered, so the read port can be registered.
    always_comb begin
        dir_addr_s  = ROM_ADDR_W'(idx_next_s * DIR_STRIDE);
        addr_next_s = rom_addr_r;
        case (state_next_s)
            ST_RD_BASE: addr_next_s = dir_addr_s;
            ST_RD_LEN:  addr_next_s = dir_addr_s + 10'd1;
            ST_FETCH:   addr_next_s = (ROM_ADDR_W'(base_r) << BASE_SHIFT) + k_next_s;
            default:    addr_next_s = rom_addr_r;
        endcase
    end

    // State, datapath and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            base_r      <= 8'd0;
            k_r         <= '0;
            remaining_r <= '0;
            rom_rd_r    <= 1'b0;
            rom_addr_r  <= '0;
            out_char_r  <= 8'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            k_r         <= k_next_s;
            remaining_r <= remaining_next_s;
            if (state_r == ST_RD_LEN) begin
                base_r <= rom_data;
            end
            if (state_r == ST_CAPT) begin
                out_char_r <= rom_data;
            end
            rom_rd_r    <= (state_next_s == ST_RD_BASE) || (state_next_s == ST_RD_LEN) ||
                           (state_next_s == ST_FETCH);
            rom_addr_r  <= addr_next_s;
            out_valid_r <= (state_next_s == ST_PRESENT);
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    assign rom_rd          = rom_rd_r;
    assign rom_addr        = rom_addr_r;
    assign out_char        = out_char_r;
    assign out_valid       = out_valid_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign chars_remaining = remaining_r;
    assign which_state     = state_r;

endmodule

// File: tb/tb_laplace_lut_sequencer.sv
// Directed bench for laplace_lut_sequencer: a transaction-level model of the
// ROM walk and character stream, plus literal latency and content checks.
module tb_laplace_lut_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] idx = 5'd0;
    logic       abort = 1'b0;
    logic       rom_rd;
    logic [9:0] rom_addr;
    logic [7:0] rom_data = 8'd0;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       done;
    logic [7:0] chars_remaining;
    logic [3:0] which_state;

    laplace_lut_sequencer #(.IDX_W(5), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .idx(idx), .abort(abort),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .chars_remaining(chars_remaining),
        .which_state(which_state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         first_valid_cyc = -1;
    int         done_cyc = -1;
    int         done_cnt = 0;
    int         acc_cnt = 0;
    logic [9:0] exp_addr_q [$];
    logic [7:0] exp_char_q [$];
    logic [7:0] acc_log [$];
    logic [9:0] addr_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM model: registered read, data valid the cycle after rom_rd.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rom_rd === 1'b1) rom_data <= mem[rom_addr];
    end

    // Compare process: checks reads, stream content and completion every cycle.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_char;
        logic [7:0] e8;
        logic [9:0] e10;
        prev_stall = 1'b0;
        prev_char  = 8'd0;
        forever begin
            @(negedge clk);
            if (rom_rd === 1'b1) begin
                addr_log.push_back(rom_addr);
                if (exp_addr_q.size() == 0) begin
                    check("rom_read_unexpected", {22'd0, rom_addr}, 32'hFFFF_FFFF);
                end else begin
                    e10 = exp_addr_q.pop_front();
                    check("rom_addr", {22'd0, rom_addr}, {22'd0, e10});
                end
            end
            if (out_valid === 1'b1 && prev_stall)
                check("out_char_stable", {24'd0, out_char}, {24'd0, prev_char});
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid === 1'b1 && out_ready && !abort && !rst) begin
                if (exp_char_q.size() == 0) begin
                    check("handshake_unexpected", {24'd0, out_char}, 32'hFFFF_FFFF);
                end else begin
                    check("chars_remaining", {24'd0, chars_remaining}, exp_char_q.size());
                    e8 = exp_char_q.pop_front();
                    check("out_char", {24'd0, out_char}, {24'd0, e8});
                end
                acc_log.push_back(out_char);
                acc_cnt++;
            end
            if (done === 1'b1) begin
                check("done_remaining", {24'd0, chars_remaining}, 32'd0);
                check("done_chars_left", exp_char_q.size(), 32'd0);
                done_cyc = cyc;
                done_cnt++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready && !abort && !rst;
            prev_char  = out_char;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_addr_q.delete();
        exp_char_q.delete();
    endtask

    task automatic launch(input int i);
        int   base;
        int   len;
        int   a;
        base = int'(mem[2*i]);
        len  = int'(mem[2*i+1]);
        acc_log.delete();
        addr_log.delete();
        first_valid_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        acc_cnt  = 0;
        exp_addr_q.push_back(10'(2*i));
        exp_addr_q.push_back(10'(2*i+1));
        for (int k = 0; k < len; k++) begin
            a = (base*4 + k) % 1024;
            exp_addr_q.push_back(10'(a));
            exp_char_q.push_back(mem[a]);
        end
        start   = 1'b1;
        idx     = 5'(i);
        t_start = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", done_cnt, 32'd1);
        tick();
        check("idle_after_done", {28'd0, which_state}, 32'd0);
    endtask

    task automatic wait_second_char(input int budget);
        int n;
        n = 0;
        while (!(out_valid === 1'b1 && acc_cnt == 1) && n < budget) begin
            tick();
            n++;
        end
        check("second_char_reached", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_rd"}, {31'd0, rom_rd}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_remaining"}, {24'd0, chars_remaining}, 32'd0);
        check({tag, "_state"}, {28'd0, which_state}, 32'd0);
    endtask

    task automatic check_s_plus_1();
        check("acc_count", acc_log.size(), 32'd3);
        if (acc_log.size() == 3) begin
            check("char0_s", {24'd0, acc_log[0]}, 32'h73);
            check("char1_plus", {24'd0, acc_log[1]}, 32'h2B);
            check("char2_one", {24'd0, acc_log[2]}, 32'h31);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        mem[6]  = 8'h10; mem[7]  = 8'd3;
        mem[10] = 8'h00; mem[11] = 8'd0;
        mem[14] = 8'hFF; mem[15] = 8'd4;
        mem[10'h040] = 8'h73; mem[10'h041] = 8'h2B; mem[10'h042] = 8'h31;
        mem[10'h3FC] = 8'h61; mem[10'h3FD] = 8'h62; mem[10'h3FE] = 8'h63; mem[10'h3FF] = 8'h64;

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        check("reset_out_char", {24'd0, out_char}, 32'd0);
        check("reset_rom_addr", {22'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // Nominal entry 3
        launch(3);
        wait_done(60);
        check("nom_first_valid", first_valid_cyc - t_start, 32'd6);
        check("nom_done_time", done_cyc - t_start, 32'd13);
        check_s_plus_1();
        check("nom_addr_count", addr_log.size(), 32'd5);
        if (addr_log.size() == 5) begin
            check("nom_addr0", {22'd0, addr_log[0]}, 32'd6);
            check("nom_addr2", {22'd0, addr_log[2]}, 32'h40);
            check("nom_addr4", {22'd0, addr_log[4]}, 32'h42);
        end

        // Backpressure on second character
        launch(3);
        wait_second_char(40);
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        wait_done(60);
        check("bp_done_time", done_cyc - t_start, 32'd17);
        check_s_plus_1();

        // Empty entry
        launch(5);
        wait_done(30);
        check("empty_done_time", done_cyc - t_start, 32'd4);
        check("empty_no_valid", first_valid_cyc, 32'hFFFF_FFFF);
        check("empty_reads", addr_log.size(), 32'd2);

        // Wrap-around entry 7
        launch(7);
        wait_done(60);
        check("wrap_done_time", done_cyc - t_start, 32'd16);
        check("wrap_count", acc_cnt, 32'd4);
        if (addr_log.size() == 6) begin
            check("wrap_addr_first", {22'd0, addr_log[2]}, 32'h3FC);
            check("wrap_addr_last", {22'd0, addr_log[5]}, 32'h3FF);
        end else begin
            check("wrap_reads", addr_log.size(), 32'd6);
        end

        // Abort during second character, then replay
        launch(3);
        wait_second_char(40);
        abort = 1'b1;
        flush();
        tick();
        abort = 1'b0;
        check_all_zero("abort");
        repeat (5) tick();
        check("abort_no_done", done_cnt, 32'd0);
        launch(3);
        wait_done(60);
        check("replay_done_time", done_cyc - t_start, 32'd13);
        check_s_plus_1();

        // Start during a sequence is ignored
        launch(3);
        repeat (6) tick();
        start = 1'b1;
        idx   = 5'd5;
        tick();
        start = 1'b0;
        wait_done(60);
        check("ignore_done_time", done_cyc - t_start, 32'd13);
        check_s_plus_1();

        // Reset mid-stream
        launch(3);
        wait_second_char(40);
        rst = 1'b1;
        tick();
        flush();
        check_all_zero("midrst");
        check("midrst_out_char", {24'd0, out_char}, 32'd0);
        check("midrst_rom_addr", {22'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_no_done", done_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/laplace_lut_sequencer.md
# laplace_lut_sequencer

Sequencer for the Laplace-transform lookup table in the `tt_um_phansel_laplace_lut` top level. On a start strobe it reads the selected entry's directory record from the character ROM, then fetches the entry's characters one at a time and presents them on a valid/ready byte stream. It exposes `chars_remaining` and `which_state` for the top level's debug outputs. The ROM is an external instance; this block only drives its read port.

## Interface
Parameters:
- `IDX_W`, default 5: entry selector width. The directory holds 2^IDX_W two-byte records.
- `LEN_W`, default 8: width of the length/remaining counter.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request pulse. Sampled only in IDLE.
- `idx`  in  IDX_W: entry to play. Captured with `start`.
- `abort`  in  1: cancels any sequence in progress.
- `rom_rd`  out  1: ROM read strobe. Registered output.
- `rom_addr`  out  10: ROM byte address. Registered output.
- `rom_data`  in  8: ROM read data, valid the cycle after `rom_rd`.
- `out_char`  out  8: character on the output stream.
- `out_valid`  out  1: `out_char` is valid.
- `out_ready`  in  1: downstream accepts `out_char`.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse when an entry completes.
- `chars_remaining`  out  LEN_W: characters not yet accepted downstream.
- `which_state`  out  4: current state code (see Operation).

## Operation
ROM layout:
- Record for entry i is at addresses 2i and 2i+1.
- Byte 2i is the base word. The first character is at byte address base·4.
- Byte 2i+1 is the length in characters, 0–255.
- Character k is at address (base·4 + k) mod 1024. Address arithmetic wraps at 10 bits.

States and `which_state` codes:
- IDLE (0): wait for `start`.
- RD_BASE (1): `rom_rd`=1, `rom_addr`=2·idx.
- RD_LEN (2): `rom_rd`=1, `rom_addr`=2·idx+1. Latch `rom_data` as base.
- LEN_CAP (3): latch `rom_data` into `chars_remaining` and clear offset k. Next state is DONE if length = 0, otherwise FETCH.
- FETCH (4): `rom_rd`=1, `rom_addr`=base·4+k.
- CAPT (5): latch `rom_data` into `out_char`; set `out_valid` for the next cycle.
- PRESENT (6): hold `out_valid`=1 and `out_char` stable until `out_valid && out_ready`. On that handshake:
  - decrement `chars_remaining` and increment k;
  - if the decremented value is 0, next state is DONE and `out_valid` drops;
  - otherwise next state is FETCH.
- DONE (7): `done`=1 for exactly this cycle, then IDLE.

Transition rules:
- `rom_rd` is 0 in every state not listed above as reading the ROM.
- `start` outside IDLE is ignored; `idx` is not recaptured.
- `abort` has priority over `start` and over a handshake in the same cycle. On the next cycle: state is IDLE, `out_valid`=0, `rom_rd`=0, `chars_remaining`=0, and no `done` pulse is produced.
- `abort` while in IDLE has no effect.
- `rst` has priority over `abort`.

## Timing
Reset values, the cycle after `rst` is sampled high:
- state IDLE;
- all outputs 0, including `out_char`, `rom_addr`, `chars_remaining` and `which_state`.

Reset mid-stream drops the stream immediately, without a `done` pulse.

Latency, with `start` sampled at cycle T:
- RD_BASE at T+1.
- LEN_CAP at T+3.
- First FETCH at T+4.
- First `out_valid` at T+6.

Throughput:
- Each character takes 3 cycles when `out_ready` is held high.
- Each low-`out_ready` cycle spent in PRESENT adds one cycle.

Completion:
- For length N with `out_ready` always high, `done` is at T+4+3N.
- For length 0, `done` is at T+4 and `out_valid` never rises.

Stream rule: `out_char` changes only in the cycle after a handshake or after CAPT, never while `out_valid && !out_ready`.

## Structure
- Package `laplace_lut_pkg` holds:
  - the state enum with the explicit 4-bit codes above;
  - `ROM_ADDR_W`=10;
  - `BASE_SHIFT`=2;
  - `DIR_STRIDE`=2.
- No sub-module. The FSM, offset counter and remaining counter sit in a single module.
- The ROM itself is `laplace_lut_rom`, instantiated beside this block in the top level.

## Test plan
The ROM model has:
- entry 3 = {base 0x10, len 3}, characters at 0x40–0x42 = "s+1";
- entry 5 = {base 0x00, len 0};
- entry 7 = {base 0xFF, len 4}.

Scenarios:
- Nominal: `start` with `idx`=3 at cycle T, `out_ready`=1 → ROM reads at addresses 6, 7, 0x40, 0x41, 0x42; stream "s", "+", "1" with first `out_valid` at T+6; `chars_remaining` goes 3→2→1→0; `done` at T+13; `which_state` returns to 0.
- Backpressure: `idx`=3 with `out_ready` low for 4 cycles on the second character → `out_char` holds "+" stably; `done` is 4 cycles later than nominal; no character is duplicated or lost.
- Empty entry: `start` with `idx`=5 → `done` at T+4; `out_valid` never rises; `chars_remaining` stays 0.
- Wrap-around: `start` with `idx`=7 → character reads at addresses 0x3FC, 0x3FD, 0x3FE, 0x3FF; 4 characters emitted, then `done`.
- Abort and restart: `abort` asserted in PRESENT with `out_ready`=1 on the second character of entry 3 → IDLE next cycle, `out_valid`=0, `chars_remaining`=0, no `done`. A following `start` with `idx`=3 replays "s+1" in full.
- Ignore/reset: a `start` with `idx`=5 during entry 3 is ignored and the output is still "s+1". `rst` asserted mid-stream → all outputs 0 the next cycle.
